// File: rtl/keccak_arbiter_pkg.sv
// Shared types and constants for the keccak core arbiter: FSM encoding,
// core word/digest widths and the round-robin pointer advance.
package keccak_arbiter_pkg;

  localparam int WORD_W   = 32;
  localparam int DIGEST_W = 512;
  localparam int BN_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_FEED = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } arb_state_t;

  // Requester after g, wrapping at n; the one just served drops to lowest priority.
  function automatic int next_rr(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/keccak_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping, returned both one-hot and as an index.
module keccak_arbiter_rr
  import keccak_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDW-1:0]  gnt_idx
);

  logic [NREQ-1:0] rot;
  logic            hit;
  int              idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    hit     = 1'b0;
    idx     = 0;
    rot     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      rot = req >> idx;
      if (!hit && rot[0]) begin
        hit     = 1'b1;
        gnt_idx = IDW'(idx);
        gnt_oh  = NREQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak core among NREQ requesters: whole-message round-robin
// grant, core reset pulse, word streaming, digest capture and handback.
module keccak_arbiter
  import keccak_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  parameter int MAX_WAIT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [WORD_W*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  input  logic [BN_W*NREQ-1:0]     req_byte_num,
  output logic [NREQ-1:0]          req_ready,
  output logic                     core_reset,
  output logic [WORD_W-1:0]        core_in,
  output logic                     core_in_ready,
  output logic                     core_is_last,
  output logic [BN_W-1:0]          core_byte_num,
  input  logic                     core_buffer_full,
  input  logic [DIGEST_W-1:0]      core_out,
  input  logic                     core_out_ready,
  output logic                     dgst_valid,
  output logic [IDW-1:0]           dgst_id,
  output logic [DIGEST_W-1:0]      dgst,
  input  logic                     dgst_ready,
  output logic                     timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  arb_state_t        state, state_nxt;
  logic [IDW-1:0]    grant, rr_ptr, pick_idx;
  logic [NREQ-1:0]   pick_oh;
  logic [CNT_W-1:0]  wait_cnt;
  logic              sel_valid, sel_last, accept;
  logic [WORD_W-1:0] sel_data;
  logic [BN_W-1:0]   sel_bn;

  keccak_arbiter_rr #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  // Fields of the granted requester only; others are never looked at mid-message.
  always_comb begin
    sel_valid = |(req_valid & (NREQ'(1) << grant));
    sel_last  = |(req_last & (NREQ'(1) << grant));
    sel_data  = WORD_W'(req_data >> (WORD_W * int'(grant)));
    sel_bn    = BN_W'(req_byte_num >> (BN_W * int'(grant)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    core_reset    = 1'b0;
    core_in       = '0;
    core_in_ready = 1'b0;
    core_is_last  = 1'b0;
    core_byte_num = '0;
    req_ready     = '0;
    dgst_valid    = 1'b0;
    accept        = 1'b0;
    case (state)
      ST_IDLE: if (|pick_oh) state_nxt = ST_RST;
      ST_RST: begin
        core_reset = 1'b1;
        state_nxt  = ST_FEED;
      end
      ST_FEED: begin
        core_in       = sel_data;
        core_is_last  = sel_last;
        core_byte_num = sel_bn;
        accept        = sel_valid & ~core_buffer_full;
        core_in_ready = accept;
        req_ready     = accept ? (NREQ'(1) << grant) : '0;
        if (accept && sel_last) state_nxt = ST_WAIT;
      end
      ST_WAIT: if (core_out_ready) state_nxt = ST_DONE;
      ST_DONE: begin
        dgst_valid = 1'b1;
        if (dgst_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter saturates at MAX_WAIT so timeout fires once and the FSM just keeps waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant    <= '0;
      rr_ptr   <= '0;
      wait_cnt <= '0;
      timeout  <= 1'b0;
      dgst     <= '0;
      dgst_id  <= '0;
    end else begin
      if (state == ST_IDLE && |pick_oh) grant <= pick_idx;
      if (state == ST_WAIT) begin
        if (wait_cnt != CNT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + CNT_W'(1);
        if (wait_cnt == CNT_W'(MAX_WAIT - 1)) timeout <= 1'b1;
        if (core_out_ready) begin
          dgst    <= core_out;
          dgst_id <= grant;
        end
      end else begin
        wait_cnt <= '0;
      end
      if (state == ST_DONE && dgst_ready) rr_ptr <= IDW'(next_rr(int'(grant), NREQ));
    end
  end

endmodule
